adder_fp: RTL and testbench

ADDER_FP -- requirements
Module: adder_fp

---
 rtl/adder_fp.sv | 200 ++++++++++++++++++++
 tb/tb_adder_fp.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_fp.sv
// adder_fp: multi-cycle IEEE-754 single-precision adder with truncation.
//
// A request is accepted in IDLE when start is high; the operands are captured
// on that edge and walk through ALIGN -> ADD -> NORM -> DONE, one state per
// clock. The result appears on Y on entry to DONE together with a one-cycle
// ready pulse, so every request (specials included) takes exactly four cycles.
// Denormal inputs are flushed to zero, results never go subnormal, and bits
// shifted out during alignment are simply dropped.
//
// Ports:
//   clk    in   1  rising-edge clock
//   reset  in   1  asynchronous active-high reset (clears FSM, ready, busy, Y)
//   start  in   1  request strobe, only looked at in IDLE
//   A, B   in  32  single-precision operands
//   ready  out  1  high for the single DONE cycle; Y holds the new sum
//   busy   out  1  high in ALIGN, ADD and NORM
//   Y      out 32  sum A+B, held until the next DONE
module adder_fp (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        ready,
    output logic        busy,
    output logic [31:0] Y
);

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

    state_t state, state_next;

    // Counts leading zeros of a 24-bit mantissa; the NORM shift is done in one
    // cycle from this value.
    function automatic logic [4:0] lzc24(input logic [23:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd0;
        found = 1'b0;
        for (int i = 23; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      n = n + 5'd1;
            end
        end
        return n;
    endfunction

    // Saturates a normalized result: overflow becomes signed infinity,
    // underflow becomes signed zero.
    function automatic logic [31:0] pack_sat(input logic s,
                                             input logic signed [9:0] e,
                                             input logic [22:0] f);
        if (e >= 10'sd255)     return {s, 8'hFF, 23'd0};
        else if (e <= 10'sd0)  return {s, 31'd0};
        else                   return {s, e[7:0], f};
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ALIGN;
            ALIGN:   state_next = ADD;
            ADD:     state_next = NORM;
            NORM:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state == ALIGN) || (state == ADD) || (state == NORM);
        ready = (state == DONE);
    end

    // ---- stage p0: operand capture in IDLE ----
    logic [31:0] a_p0, b_p0;

    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            a_p0 <= A;
            b_p0 <= B;
        end
    end

    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic        spec_al;
    logic [31:0] spec_y_al;
    logic [31:0] big_al, sml_al;
    logic [7:0]  diff_al;
    logic [23:0] sml_sh_al;

    always_comb begin
        a_zero = (a_p0[30:23] == 8'd0);
        b_zero = (b_p0[30:23] == 8'd0);
        a_inf  = (a_p0[30:23] == 8'hFF) && (a_p0[22:0] == 23'd0);
        b_inf  = (b_p0[30:23] == 8'hFF) && (b_p0[22:0] == 23'd0);
        a_nan  = (a_p0[30:23] == 8'hFF) && (a_p0[22:0] != 23'd0);
        b_nan  = (b_p0[30:23] == 8'hFF) && (b_p0[22:0] != 23'd0);

        spec_al   = 1'b1;
        spec_y_al = QNAN;
        if (a_nan || b_nan)        spec_y_al = QNAN;
        else if (a_inf && b_inf)   spec_y_al = (a_p0[31] == b_p0[31]) ? a_p0 : QNAN;
        else if (a_inf)            spec_y_al = a_p0;
        else if (b_inf)            spec_y_al = b_p0;
        else if (a_zero && b_zero) spec_y_al = {a_p0[31] & b_p0[31], 31'd0};
        else if (a_zero)           spec_y_al = b_p0;
        else if (b_zero)           spec_y_al = a_p0;
        else                       spec_al   = 1'b0;

        // Exponent-then-fraction ordering is exactly an unsigned compare of
        // the low 31 bits.
        if (a_p0[30:0] >= b_p0[30:0]) begin
            big_al = a_p0;
            sml_al = b_p0;
        end else begin
            big_al = b_p0;
            sml_al = a_p0;
        end
        diff_al = big_al[30:23] - sml_al[30:23];
        // A shift of 24 or more clears the 24-bit mantissa entirely.
        sml_sh_al = {1'b1, sml_al[22:0]} >> diff_al;
    end

    // ---- stage p1: aligned mantissas ----
    logic        sign_big_p1, sign_sml_p1, spec_p1;
    logic [31:0] spec_y_p1;
    logic [7:0]  exp_p1;
    logic [23:0] mant_big_p1, mant_sml_p1;

    always_ff @(posedge clk) begin
        if (state == ALIGN) begin
            sign_big_p1 <= big_al[31];
            sign_sml_p1 <= sml_al[31];
            exp_p1      <= big_al[30:23];
            mant_big_p1 <= {1'b1, big_al[22:0]};
            mant_sml_p1 <= sml_sh_al;
            spec_p1     <= spec_al;
            spec_y_p1   <= spec_y_al;
        end
    end

    logic [24:0] sum_ad;

    always_comb begin
        // big >= small in magnitude, so the difference never goes negative.
        if (sign_big_p1 == sign_sml_p1) sum_ad = {1'b0, mant_big_p1} + {1'b0, mant_sml_p1};
        else                            sum_ad = {1'b0, mant_big_p1} - {1'b0, mant_sml_p1};
    end

    // ---- stage p2: raw sum ----
    logic        sign_p2, spec_p2;
    logic [31:0] spec_y_p2;
    logic [7:0]  exp_p2;
    logic [24:0] sum_p2;

    always_ff @(posedge clk) begin
        if (state == ADD) begin
            sign_p2   <= sign_big_p1;
            exp_p2    <= exp_p1;
            sum_p2    <= sum_ad;
            spec_p2   <= spec_p1;
            spec_y_p2 <= spec_y_p1;
        end
    end

    logic [4:0]         lz_nm;
    logic [23:0]        mant_nm;
    logic signed [9:0]  exp_nm;
    logic [31:0]        y_nm;

    always_comb begin
        lz_nm = lzc24(sum_p2[23:0]);
        if (sum_p2[24]) begin
            mant_nm = sum_p2[24:1];
            exp_nm  = $signed({2'b00, exp_p2}) + 10'sd1;
        end else begin
            mant_nm = sum_p2[23:0] << lz_nm;
            exp_nm  = $signed({2'b00, exp_p2}) - $signed({5'd0, lz_nm});
        end
        if (spec_p2)               y_nm = spec_y_p2;
        else if (sum_p2 == 25'd0)  y_nm = 32'd0;
        else                       y_nm = pack_sat(sign_p2, exp_nm, mant_nm[22:0]);
    end

    // ---- result register: loaded on the NORM -> DONE edge ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset)              Y <= 32'd0;
        else if (state == NORM) Y <= y_nm;
    end

endmodule

// File: tb/tb_adder_fp.sv
// Self-checking bench for adder_fp: reset values, directed vectors with known
// sums, randomized operands against a value-level truncating-add model,
// start held through busy, and asynchronous reset in the middle of a request.
module tb_adder_fp;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] A, B;
    logic        ready, busy;
    logic [31:0] Y;

    int n_checks = 0;
    int n_fail   = 0;

    adder_fp dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .A     (A),
        .B     (B),
        .ready (ready),
        .busy  (busy),
        .Y     (Y)
    );

    always #5 clk = ~clk;

    // Value-level reference: exact integer mantissas, small operand truncated
    // by integer division when aligned, then renormalized around the top bit.
    function automatic logic [31:0] model_add(input logic [31:0] a, input logic [31:0] b);
        logic   s_big, s_sml;
        int     ea, eb, e_big, e_sml, d, p, e;
        longint fa, fb, f_big, f_sml, m_big, m_sml, contrib, r, mant;
        ea = int'(a[30:23]);  eb = int'(b[30:23]);
        fa = longint'(a[22:0]); fb = longint'(b[22:0]);
        if ((ea == 255 && fa != 0) || (eb == 255 && fb != 0)) return 32'h7FC00000;
        if (ea == 255 && eb == 255) return (a[31] == b[31]) ? a : 32'h7FC00000;
        if (ea == 255) return a;
        if (eb == 255) return b;
        if (ea == 0 && eb == 0) return {a[31] & b[31], 31'd0};
        if (ea == 0) return b;
        if (eb == 0) return a;
        if (longint'(ea) * 8388608 + fa >= longint'(eb) * 8388608 + fb) begin
            s_big = a[31]; e_big = ea; f_big = fa; s_sml = b[31]; e_sml = eb; f_sml = fb;
        end else begin
            s_big = b[31]; e_big = eb; f_big = fb; s_sml = a[31]; e_sml = ea; f_sml = fa;
        end
        m_big = 8388608 + f_big;
        m_sml = 8388608 + f_sml;
        d = e_big - e_sml;
        contrib = (d >= 40) ? 0 : m_sml / (longint'(1) << d);
        r = (s_big == s_sml) ? m_big + contrib : m_big - contrib;
        if (r == 0) return 32'd0;
        p = 0;
        for (int i = 0; i < 40; i++) if (((r >> i) & 1) != 0) p = i;
        e = e_big + p - 23;
        mant = (p > 23) ? (r >> (p - 23)) : (r << (23 - p));
        if (e >= 255) return {s_big, 8'hFF, 23'd0};
        if (e <= 0)   return {s_big, 31'd0};
        return {s_big, e[7:0], mant[22:0]};
    endfunction

    function automatic logic [31:0] gen_operand(input int base);
        int          kind, e;
        logic [31:0] fr;
        logic        s;
        kind = int'($urandom_range(0, 15));
        fr   = $urandom;
        s    = fr[31];
        if (kind == 0) return {s, 8'd0, (kind == 0 && fr[30]) ? 23'd0 : fr[22:0]};
        if (kind == 1) return {s, 8'hFF, fr[30] ? 23'd0 : (fr[22:0] | 23'd1)};
        e = base + int'($urandom_range(0, 60)) - 30;
        if (e < 1)   e = 1;
        if (e > 254) e = 254;
        return {s, e[7:0], fr[22:0]};
    endfunction

    // Runs one request and records what the outputs did over cycles 1..8
    // after the start-sampling edge. Operands are scrambled once latched.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] y_cap, output int rdy_cnt,
                         output int rdy_cyc, output logic [8:0] busy_mask,
                         output logic [31:0] y_end);
        rdy_cnt = 0; rdy_cyc = 0; busy_mask = '0; y_cap = '0;
        @(negedge clk);
        A = a; B = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0; A = $urandom; B = $urandom;
        for (int c = 1; c <= 8; c++) begin
            busy_mask[c] = busy;
            if (ready) begin
                rdy_cnt++;
                if (rdy_cyc == 0) begin
                    rdy_cyc = c;
                    y_cap   = Y;
                end
            end
            if (c < 8) @(negedge clk);
        end
        y_end = Y;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; A = '0; B = '0;
        #1;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++;
        if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", ready); end
        repeat (2) @(negedge clk);
        n_checks++;
        if (Y !== 32'h0) begin n_fail++; $display("FAIL reset_y: got %h expected 00000000", Y); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [31:0] va [8];
        logic [31:0] vb [8];
        logic [31:0] vy [8];
        logic [31:0] y_cap, y_end;
        int          rc, rcyc;
        logic [8:0]  bm;
        va = '{32'h40C00000, 32'h40C00000, 32'h3F800000, 32'h7F7FFFFF,
               32'h00000000, 32'h7F800000, 32'h7FF00000, 32'h7F800000};
        vb = '{32'h41A00000, 32'hC0C00000, 32'h30800000, 32'h7F7FFFFF,
               32'h5AA42FFF, 32'hFF800000, 32'h41A00000, 32'h41A00000};
        vy = '{32'h41D00000, 32'h00000000, 32'h3F800000, 32'h7F800000,
               32'h5AA42FFF, 32'h7FC00000, 32'h7FC00000, 32'h7F800000};
        for (int i = 0; i < 8; i++) begin
            do_op(va[i], vb[i], y_cap, rc, rcyc, bm, y_end);
            n_checks++;
            if (y_cap !== vy[i]) begin
                n_fail++; $display("FAIL directed_y[%0d]: got %h expected %h", i, y_cap, vy[i]);
            end
            n_checks++;
            if (rc != 1 || rcyc != 4) begin
                n_fail++; $display("FAIL directed_ready[%0d]: got %0d pulses at cycle %0d expected 1 at cycle 4", i, rc, rcyc);
            end
            n_checks++;
            if (bm !== 9'b0_0000_1110) begin
                n_fail++; $display("FAIL directed_busy[%0d]: got %b expected 000001110", i, bm);
            end
            n_checks++;
            if (y_end !== vy[i]) begin
                n_fail++; $display("FAIL directed_hold[%0d]: got %h expected %h", i, y_end, vy[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, exp_y, y_cap, y_end;
        int          rc, rcyc, base;
        logic [8:0]  bm;
        for (int i = 0; i < 80; i++) begin
            base = int'($urandom_range(1, 254));
            a = gen_operand(base);
            b = gen_operand(base);
            if ($urandom_range(0, 7) == 0) b = a ^ 32'h80000000;
            exp_y = model_add(a, b);
            do_op(a, b, y_cap, rc, rcyc, bm, y_end);
            n_checks++;
            if (y_cap !== exp_y) begin
                n_fail++; $display("FAIL random_y a=%h b=%h: got %h expected %h", a, b, y_cap, exp_y);
            end
            n_checks++;
            if (rc != 1 || rcyc != 4 || bm !== 9'b0_0000_1110) begin
                n_fail++; $display("FAIL random_timing a=%h b=%h: got %0d pulses at %0d busy %b expected 1 at 4 busy 000001110", a, b, rc, rcyc, bm);
            end
        end
    endtask

    task automatic test_start_held();
        logic [31:0] a0, b0, exp_y, y_got;
        int          cnt, rcyc;
        a0 = 32'h3FC00000;                 // 1.5
        b0 = 32'hC1100000 ^ ($urandom & 32'h007FFFFF);
        exp_y = model_add(a0, b0);
        cnt = 0; rcyc = 0; y_got = '0;
        @(negedge clk);
        A = a0; B = b0; start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c < 3) begin A = $urandom; B = $urandom; end
            else start = 1'b0;
            if (ready) begin
                cnt++;
                if (rcyc == 0) begin rcyc = c; y_got = Y; end
            end
        end
        start = 1'b0;
        n_checks++;
        if (cnt != 1 || rcyc != 4) begin
            n_fail++; $display("FAIL held_ready: got %0d pulses at cycle %0d expected 1 at cycle 4", cnt, rcyc);
        end
        n_checks++;
        if (y_got !== exp_y) begin
            n_fail++; $display("FAIL held_y: got %h expected %h", y_got, exp_y);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] y_cap, y_end;
        int          rc, rcyc, cnt;
        logic [8:0]  bm;
        do_op(32'h40C00000, 32'h41A00000, y_cap, rc, rcyc, bm, y_end);
        @(negedge clk);
        A = 32'h3F800000; B = 32'h3F800000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);                    // now in ADD
        n_checks++;
        if (busy !== 1'b1 || Y !== 32'h41D00000) begin
            n_fail++; $display("FAIL mid_pre: got busy=%b y=%h expected busy=1 y=41d00000", busy, Y);
        end
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if (busy !== 1'b0 || ready !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_ctrl: got busy=%b ready=%b expected 0 0", busy, ready);
        end
        n_checks++;
        if (Y !== 32'h0) begin
            n_fail++; $display("FAIL mid_reset_y: got %h expected 00000000", Y);
        end
        #1 reset = 1'b0;
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (ready) cnt++;
        end
        n_checks++;
        if (cnt != 0 || Y !== 32'h0) begin
            n_fail++; $display("FAIL mid_no_ready: got %0d pulses y=%h expected 0 pulses y=00000000", cnt, Y);
        end
        do_op(32'h3F800000, 32'h3F800000, y_cap, rc, rcyc, bm, y_end);
        n_checks++;
        if (y_cap !== 32'h40000000 || rc != 1 || rcyc != 4) begin
            n_fail++; $display("FAIL mid_restart: got y=%h %0d pulses at %0d expected 40000000 1 at 4", y_cap, rc, rcyc);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_held();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
